onchip_memory_arbiter: RTL

Two-master arbiter that shares the single-port on-chip program/data RAM (14-bit word address, 32-bit data, byte enables, one-cycle read latency) between the Nios II data master (m0) and the AES accelerator DMA engine (m1). Each side presents a pipelined Avalon-MM slave port with waitrequest and readdatavalid. The memory side drives the RAM's address, byteenable, chipselect, write, writedata and clken inputs and samples its readdata. The block sits in the Qsys fabric between the two masters and the RAM instance.

---
 rtl/onchip_memory_arbiter.sv | 68 ++++++
 1 files changed

// File: rtl/onchip_memory_arbiter.sv
// onchip_memory_arbiter: shares a single-port, one-cycle-latency RAM between two pipelined Avalon-MM masters
module onchip_memory_arbiter #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 32,
   parameter int FIXED_PRIORITY = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  hold,
   input  logic [ADDR_W-1:0]     m0_address,
   input  logic [DATA_W/8-1:0]   m0_byteenable,
   input  logic                  m0_read,
   input  logic                  m0_write,
   input  logic [DATA_W-1:0]     m0_writedata,
   output logic                  m0_waitrequest,
   output logic [DATA_W-1:0]     m0_readdata,
   output logic                  m0_readdatavalid,
   input  logic [ADDR_W-1:0]     m1_address,
   input  logic [DATA_W/8-1:0]   m1_byteenable,
   input  logic                  m1_read,
   input  logic                  m1_write,
   input  logic [DATA_W-1:0]     m1_writedata,
   output logic                  m1_waitrequest,
   output logic [DATA_W-1:0]     m1_readdata,
   output logic                  m1_readdatavalid,
   output logic [ADDR_W-1:0]     mem_address,
   output logic [DATA_W/8-1:0]   mem_byteenable,
   output logic                  mem_chipselect,
   output logic                  mem_write,
   output logic [DATA_W-1:0]     mem_writedata,
   output logic                  mem_clken,
   input  logic [DATA_W-1:0]     mem_readdata
);
   logic req0, req1, ok, gnt0, gnt1, rd_acc;
   logic last_grant, rd_pend, rd_owner;
   always_comb begin
      req0 = m0_read | m0_write;
      req1 = m1_read | m1_write;
      ok = ~reset & ~hold;
      gnt0 = ok & req0 & (~req1 | (FIXED_PRIORITY != 0) | last_grant);
      gnt1 = ok & req1 & ~gnt0;
      // a simultaneous read+write is treated as a write, so it never produces readdatavalid
      rd_acc = (gnt0 & m0_read & ~m0_write) | (gnt1 & m1_read & ~m1_write);
      m0_waitrequest = req0 & ~gnt0;
      m1_waitrequest = req1 & ~gnt1;
      mem_address = gnt1 ? m1_address : m0_address;
      mem_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
      mem_writedata = gnt1 ? m1_writedata : m0_writedata;
      mem_chipselect = gnt0 | gnt1;
      mem_write = gnt1 ? m1_write : gnt0 & m0_write;
      mem_clken = 1'b1;
      m0_readdata = mem_readdata;
      m1_readdata = mem_readdata;
      m0_readdatavalid = ~reset & rd_pend & ~rd_owner;
      m1_readdatavalid = ~reset & rd_pend & rd_owner;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= 1'b1;
         rd_pend <= 1'b0;
         rd_owner <= 1'b0;
      end else begin
         if (gnt0 | gnt1) last_grant <= gnt1;
         rd_pend <= rd_acc;
         rd_owner <= rd_acc & gnt1;
      end
   end
endmodule
